// File: rtl/regfile_seq.sv
// Purpose : sequences one arithmetic op through the 4-entry 512-bit register file
//           (write a/b, start unit, commit s0/s1 via select, read back, respond).
// Latency : accept edge + 7 cycles to res_valid when alu_done is seen in the first WAIT cycle;
//           each further WAIT cycle adds one.
// Backpr. : response held in RESP until res_ready; cmd_ready is low everywhere except IDLE.
//
// Optional feature macro: REGFILE_SEQ_TIMEOUT_EN
//   defined   -> WAIT is bounded by TIMEOUT_CYCLES; on expiry the response carries res_err=1
//                with zero result halves.
//   undefined -> WAIT lasts until alu_done; res_err is tied low.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready             command handshake; cmd_op/cmd_a/cmd_b are the payload
//   rf_we/rf_re/rf_select           register-file controls, at most one high per cycle
//   rf_add, rf_wdata, rf_rdata      register-file address, write data, combinational read data
//   alu_start, alu_op, alu_done     arithmetic-unit start pulse, opcode, completion
//   res_valid/res_ready             response handshake; res_lo/res_hi/res_err are the payload
//   busy                            high whenever the sequencer is not idle
module regfile_seq #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [511:0] cmd_a,
    input  logic [511:0] cmd_b,
    output logic         rf_we,
    output logic         rf_re,
    output logic         rf_select,
    output logic [1:0]   rf_add,
    output logic [511:0] rf_wdata,
    input  logic [511:0] rf_rdata,
    output logic         alu_start,
    output logic [1:0]   alu_op,
    input  logic         alu_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [511:0] res_lo,
    output logic [511:0] res_hi,
    output logic         res_err,
    output logic         busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_B, S_START, S_WAIT,
        S_CAPTURE, S_RD_S0, S_RD_S1, S_RESP
    } state_e;

    state_e state_q, state_d;

    // Registered outputs: every control pin comes straight from a flop because
    // the register-file write path is level-sensitive and must never see a glitch.
    logic         cmd_ready_q, cmd_ready_d;
    logic         busy_q, busy_d;
    logic         rf_we_q, rf_we_d;
    logic         rf_re_q, rf_re_d;
    logic         rf_sel_q, rf_sel_d;
    logic [1:0]   rf_add_q, rf_add_d;
    logic [511:0] rf_wdata_q, rf_wdata_d;
    logic         alu_start_q, alu_start_d;
    logic         res_valid_q, res_valid_d;

    // Datapath holding registers. Operand a is never stored: it is driven onto
    // rf_wdata directly from cmd_a at the accept edge.
    logic [1:0]   op_q, op_d;
    logic [511:0] b_q, b_d;
    logic [511:0] res_lo_q, res_lo_d;
    logic [511:0] res_hi_q, res_hi_d;

    logic timeout;

`ifdef REGFILE_SEQ_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_err_q, res_err_d;

    // Fires in the last allowed WAIT cycle if the unit still has not finished.
    assign timeout = (state_q == S_WAIT) && !alu_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        res_err_d = res_err_q;
        if (timeout) begin
            res_err_d = 1'b1;
        end else if (state_q == S_RESP && res_ready) begin
            res_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            res_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            res_err_q <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    assign timeout = 1'b0;
    assign res_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cmd_valid) state_d = S_WR_A;
            S_WR_A:    state_d = S_WR_B;
            S_WR_B:    state_d = S_START;
            S_START:   state_d = S_WAIT;
            S_WAIT: begin
                if (alu_done) begin
                    state_d = S_CAPTURE;
                end else if (timeout) begin
                    state_d = S_RESP;
                end
            end
            S_CAPTURE: state_d = S_RD_S0;
            S_RD_S0:   state_d = S_RD_S1;
            S_RD_S1:   state_d = S_RESP;
            S_RESP:    if (res_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: decoded from the state being entered so the output flops
    // line up with the state register cycle for cycle.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rf_we_d     = (state_d == S_WR_A) || (state_d == S_WR_B);
        rf_re_d     = (state_d == S_RD_S0) || (state_d == S_RD_S1);
        rf_sel_d    = (state_d == S_CAPTURE);
        alu_start_d = (state_d == S_START);
        res_valid_d = (state_d == S_RESP);
        rf_add_d    = 2'b00;
        rf_wdata_d  = '0;
        case (state_d)
            // Only reachable from IDLE on the accept edge, so cmd_a is still current.
            S_WR_A:  rf_wdata_d = cmd_a;
            S_WR_B: begin
                rf_add_d   = 2'b01;
                rf_wdata_d = b_q;
            end
            S_RD_S0: rf_add_d = 2'b10;
            S_RD_S1: rf_add_d = 2'b11;
            default: begin
                rf_add_d   = 2'b00;
                rf_wdata_d = '0;
            end
        endcase
    end

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        b_d      = b_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        if (state_q == S_IDLE && cmd_valid) begin
            op_d = cmd_op;
            b_d  = cmd_b;
        end
        if (state_q == S_RD_S0) res_lo_d = rf_rdata;
        if (state_q == S_RD_S1) res_hi_d = rf_rdata;
        if (timeout) begin
            res_lo_d = '0;
            res_hi_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_re_q     <= 1'b0;
            rf_sel_q    <= 1'b0;
            rf_add_q    <= 2'b00;
            rf_wdata_q  <= '0;
            alu_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            op_q        <= 2'b00;
            b_q         <= '0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rf_we_q     <= rf_we_d;
            rf_re_q     <= rf_re_d;
            rf_sel_q    <= rf_sel_d;
            rf_add_q    <= rf_add_d;
            rf_wdata_q  <= rf_wdata_d;
            alu_start_q <= alu_start_d;
            res_valid_q <= res_valid_d;
            op_q        <= op_d;
            b_q         <= b_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rf_we     = rf_we_q;
    assign rf_re     = rf_re_q;
    assign rf_select = rf_sel_q;
    assign rf_add    = rf_add_q;
    assign rf_wdata  = rf_wdata_q;
    assign alu_start = alu_start_q;
    assign alu_op    = op_q;
    assign res_valid = res_valid_q;
    assign res_lo    = res_lo_q;
    assign res_hi    = res_hi_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: register-file and arithmetic-unit models around the DUT,
// directed plus random operations, results predicted from the operation definition.
// Drives inputs 1 time unit after the rising edge; observes at the same point.
module tb_regfile_seq;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [511:0] cmd_a, cmd_b;
    logic         rf_we, rf_re, rf_select;
    logic [1:0]   rf_add;
    logic [511:0] rf_wdata, rf_rdata;
    logic         alu_start, alu_done;
    logic [1:0]   alu_op;
    logic         res_valid, res_ready;
    logic [511:0] res_lo, res_hi;
    logic         res_err, busy;

    regfile_seq #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rf_we(rf_we), .rf_re(rf_re), .rf_select(rf_select), .rf_add(rf_add),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Operation definition: {hi, lo} result of the arithmetic unit.
    function automatic logic [1023:0] ref_op(input logic [1:0] op, input logic [511:0] a, input logic [511:0] b);
        logic [1023:0] r;
        case (op)
            2'd0:    r = {512'b0, a} * {512'b0, b};
            2'd1:    r = {512'b0, a} + {512'b0, b};
            2'd2:    r = {a & b, a ^ b};
            default: r = {b, a};
        endcase
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Register-file model: level write on rf_we, select commits both unit halves.
    logic [511:0] mem [4];
    logic [511:0] ldata, hdata;
    always @(posedge clk) begin
        if (rf_we) mem[rf_add] <= rf_wdata;
        if (rf_select) begin
            mem[2] <= ldata;
            mem[3] <= hdata;
        end
    end
    assign rf_rdata = rf_re ? mem[rf_add] : '0;

    // Arithmetic-unit model: done_delay cycles after the start cycle (0 = never).
    int   done_delay = 1;
    int   countdown  = 0;
    logic alu_done_r = 1'b0;
    logic stray_done = 1'b0;
    assign alu_done = alu_done_r | stray_done;
    always @(negedge clk) begin
        if (!rst_n) begin
            countdown  = 0;
            alu_done_r = 1'b0;
        end else begin
            alu_done_r = 1'b0;
            if (alu_start) begin
                countdown = done_delay;
                {hdata, ldata} = ref_op(alu_op, mem[0], mem[1]);
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) alu_done_r = 1'b1;
            end
        end
    end

    // Protocol monitor: tallies only; the checks read these tallies.
    int onehot_viol = 0, idle_viol = 0, start_cnt = 0, sel_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(rf_we) + int'(rf_re) + int'(rf_select) > 1) onehot_viol++;
            if (!(rf_we || rf_re || rf_select) && (rf_add != 2'b00 || rf_wdata != '0)) idle_viol++;
            if (alu_start) start_cnt++;
            if (rf_select) sel_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_rf_ctl", {rf_we, rf_re, rf_select}, 0);
        chk("rst_rf_add", rf_add, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_res", {res_lo[255:0], res_hi[255:0]}, 0);
        chk("rst_res_err", res_err, 0);
    endtask

    int st0, sel0;

    task automatic issue(input logic [511:0] a, input logic [511:0] b, input logic [1:0] op,
                         input int dly, input bit keep);
        done_delay = dly;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        st0 = start_cnt; sel0 = sel_cnt;
        if (!keep) cmd_valid = 1'b0;
        chk("wr_a_we", rf_we, 1);
        chk("wr_a_add", rf_add, 0);
        chk("wr_a_wdata", rf_wdata, a);
        chk("wr_a_alu_op", alu_op, op);
        chk("wr_a_ready", cmd_ready, 0);
    endtask

    task automatic wait_valid(output int lat);
        int k = 0;
        while (!res_valid && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!res_valid) chk("resp_bound", res_valid, 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic finish_resp();
        @(posedge clk); #1;
        chk("post_ready", cmd_ready, 1);
        chk("post_valid", res_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_err", res_err, 0);
    endtask

    task automatic check_result(input string tag, input logic [1023:0] e);
        chk({tag, "_lo"}, res_lo, e[511:0]);
        chk({tag, "_hi"}, res_hi, e[1023:512]);
        chk({tag, "_err"}, res_err, 0);
    endtask

    initial begin
        logic [511:0]  a, b, a2, b2;
        logic [1:0]    op, op2;
        logic [1023:0] e;
        int            lat, dly, hold;

        rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        repeat (2) @(posedge clk);
        #1 check_reset_outs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op: 5 * 7, done in first WAIT cycle.
        a = 512'd5; b = 512'd7;
        issue(a, b, 2'd0, 1, 1'b0);
        wait_valid(lat);
        chk("single_latency", lat, 7);
        chk("single_lo", res_lo, 35);
        chk("single_hi", res_hi, 0);
        chk("single_err", res_err, 0);
        finish_resp();
        chk("single_start_pulses", start_cnt - st0, 1);
        chk("single_selects", sel_cnt - sel0, 1);

        // Back-pressure: response held 10 cycles, competing command ignored.
        a = rnd512(); b = rnd512(); e = ref_op(2'd1, a, b);
        res_ready = 1'b0;
        issue(a, b, 2'd1, 2, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 8);
        cmd_a = rnd512(); cmd_b = rnd512(); cmd_op = 2'd3; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", res_valid, 1);
            chk("bp_lo", res_lo, e[511:0]);
            chk("bp_hi", res_hi, e[1023:512]);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_alu_op", alu_op, 2'd1);
        end
        cmd_valid = 1'b0; res_ready = 1'b1;
        finish_resp();

        // Slow unit with a stray alu_done during WR_B.
        a = rnd512(); b = rnd512(); e = ref_op(2'd0, a, b);
        issue(a, b, 2'd0, 50, 1'b0);
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        wait_valid(lat);
        chk("slow_latency", lat, 56);
        check_result("slow", e);
        finish_resp();
        chk("slow_start_pulses", start_cnt - st0, 1);
        chk("slow_selects", sel_cnt - sel0, 1);

`ifdef REGFILE_SEQ_TIMEOUT_EN
        // Unit never finishes: bounded wait, error response.
        issue(rnd512(), rnd512(), 2'd2, 0, 1'b0);
        wait_valid(lat);
        chk("tmo_latency", lat, 3 + TMO);
        chk("tmo_err", res_err, 1);
        chk("tmo_lo", res_lo, 0);
        chk("tmo_hi", res_hi, 0);
        chk("tmo_selects", sel_cnt - sel0, 0);
        finish_resp();
        issue(rnd512(), rnd512(), 2'd2, 0, 1'b0);
        repeat (6) @(posedge clk);
        #1 chk("wait_busy", busy, 1);
`else
        // Unit never finishes: sequencer waits indefinitely.
        issue(rnd512(), rnd512(), 2'd2, 0, 1'b0);
        repeat (200) @(posedge clk);
        #1 chk("hang_busy", busy, 1);
        chk("hang_valid", res_valid, 0);
`endif

        // Reset while in WAIT.
        #2 rst_n = 1'b0;
        #1 check_reset_outs();
        @(posedge clk); #1;
        check_reset_outs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones operand after reset.
        a = '1; b = 512'd3; e = ref_op(2'd0, a, b);
        issue(a, b, 2'd0, 3, 1'b0);
        wait_valid(lat);
        chk("ones_latency", lat, 9);
        check_result("ones", e);
        chk("ones_mem_a", mem[0], a);
        finish_resp();

        // Back-to-back with cmd_valid held high.
        a = rnd512(); b = rnd512(); op = 2'd2; e = ref_op(op, a, b);
        a2 = rnd512(); b2 = rnd512(); op2 = 2'd3;
        issue(a, b, op, 1, 1'b1);
        cmd_a = a2; cmd_b = b2; cmd_op = op2;
        wait_valid(lat);
        chk("b2b1_latency", lat, 7);
        check_result("b2b1", e);
        done_delay = 2;
        @(posedge clk); #1;
        chk("b2b_gap_ready", cmd_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        chk("b2b2_ready", cmd_ready, 0);
        chk("b2b2_alu_op", alu_op, op2);
        chk("b2b2_wdata", rf_wdata, a2);
        wait_valid(lat);
        chk("b2b2_latency", lat, 8);
        check_result("b2b2", ref_op(op2, a2, b2));
        finish_resp();

        // Random operations with random unit delay and response stall.
        for (int n = 0; n < 6; n++) begin
            a = rnd512(); b = rnd512(); op = 2'($urandom_range(0, 3));
            dly = int'($urandom_range(1, 6)); hold = int'($urandom_range(0, 3));
            e = ref_op(op, a, b);
            res_ready = (hold == 0);
            issue(a, b, op, dly, 1'b0);
            wait_valid(lat);
            chk("rnd_latency", lat, 6 + dly);
            check_result("rnd", e);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk("rnd_hold_valid", res_valid, 1);
                chk("rnd_hold_lo", res_lo, e[511:0]);
            end
            res_ready = 1'b1;
            finish_resp();
        end

        chk("onehot_rf_ctl", onehot_viol, 0);
        chk("idle_rf_bus", idle_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_seq.md
# regfile_seq

Sequencer that runs one arithmetic operation through the 512-bit four-entry register file (a, b, s0, s1). It accepts a command carrying both operands, writes them to a and b, starts the arithmetic unit, commits its low and high result halves into s0/s1 via the select path, reads both back and returns them on a valid/ready response port. It is the only master of the register-file control pins; the arithmetic unit feeds the register file's ldata/hdata inputs directly.

## Interface
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before the operation is aborted; must be ≥ 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high in IDLE only.
- cmd_op  in  2  opcode forwarded to the arithmetic unit.
- cmd_a, cmd_b  in  512 each  operands.
- rf_we, rf_re, rf_select  out  1 each  register-file controls; at most one high per cycle.
- rf_add  out  2  register-file address: 00=a, 01=b, 10=s0, 11=s1.
- rf_wdata  out  512  register-file write data.
- rf_rdata  in  512  register-file combinational read data.
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  2  latched cmd_op.
- alu_done  in  1  result halves valid on ldata/hdata.
- res_valid  out  1  response present.
- res_ready  in  1  response consumed.
- res_lo, res_hi  out  512 each  s0 and s1 contents.
- res_err  out  1  timeout abort flag.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, WR_A, WR_B, START, WAIT, CAPTURE, RD_S0, RD_S1, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_a, cmd_b, cmd_op and go to WR_A.
- WR_A: rf_we=1, rf_add=00, rf_wdata=a. Go to WR_B.
- WR_B: rf_we=1, rf_add=01, rf_wdata=b. Go to START.
- START: alu_start=1 and clear the wait counter. Go to WAIT.
- WAIT: alu_done sampled high → go to CAPTURE. alu_done is ignored in every other state.
- CAPTURE: rf_select=1 for one cycle. Go to RD_S0.
- RD_S0: rf_re=1, rf_add=10. res_lo ← rf_rdata at the edge. Go to RD_S1.
- RD_S1: rf_re=1, rf_add=11. res_hi ← rf_rdata at the edge. Go to RESP.
- RESP: res_valid=1. res_lo, res_hi and res_err are held stable until res_ready; when accepted, go to IDLE.
- All control outputs are driven from flops with no glitches: the register-file write path is level-sensitive.
- When no write, read or select is active, rf_add holds 00 and rf_wdata holds 0.
- alu_op is held constant from WR_A through RESP.

## Timing
- Cycle 0 is the accept edge.
- Cycles 1–2 are the writes; cycle 3 is alu_start.
- alu_done seen in the first WAIT cycle (cycle 4) gives CAPTURE 5, RD_S0 6, RD_S1 7, res_valid from cycle 8.
- Each extra WAIT cycle adds one cycle of latency.
- Back-to-back: a response accepted at edge N gives cmd_ready=1 in cycle N+1.
- Reset values: state IDLE, cmd_ready=1. All other outputs 0, including res_lo, res_hi, res_err, busy, alu_op and every rf_* output.
- Reset mid-operation: abort immediately with no partial write, read or select afterwards. The contents of the register file are undefined to the requester.
- res_valid with res_ready low: response held indefinitely. cmd_valid is ignored in RESP.

## Configuration
- REGFILE_SEQ_TIMEOUT_EN defined:
  - A wait counter increments each WAIT cycle.
  - If alu_done is still low after TIMEOUT_CYCLES WAIT cycles, go directly to RESP with res_err=1 and res_lo=res_hi=0. CAPTURE and the reads are skipped.
  - res_err clears when the response is accepted.
- REGFILE_SEQ_TIMEOUT_EN undefined:
  - No counter; WAIT lasts until alu_done.
  - res_err is tied to 0.

## Test plan
- Single op: a=5, b=7, alu_done 1 cycle after START with ldata=35, hdata=0, res_ready held high → res_valid in cycle 8, res_lo=35, res_hi=0, res_err=0. Monitor checks at most one of rf_we, rf_re, rf_select per cycle.
- Back-pressure: res_ready low for 10 cycles → res_valid, res_lo and res_hi stable throughout; cmd_ready=0 throughout; new cmd_valid is not accepted.
- Slow unit: alu_done 50 cycles after START → res_valid 49 cycles later than in the single-op case; alu_start is high exactly one cycle; alu_done pulsed during WR_B is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=16): alu_done never asserted → res_valid 16 WAIT cycles after START with res_err=1 and res_lo=res_hi=0; rf_select never asserted. Macro off: same stimulus → busy stays 1 indefinitely.
- Reset in WAIT: rst_n low → all outputs 0 and cmd_ready=1 asynchronously. After release, a new command with a=0xFF..FF (all 512 bits) completes normally with correct rf_wdata.
- Back-to-back: two commands with cmd_valid held high → second accepted in the cycle after the first response is accepted; alu_op shows the second cmd_op from the second WR_A.
